// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RV32 load/store width encodings, the sequencing FSM state type,
// the address/data widths, and helpers that decode func3 into an access
// size and a legality flag.
package load_store_unit_pkg;

  localparam int AddrWidth = 32;
  localparam int DataWidth = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  // Unshifted byte mask for the access size; zero for codes with no size.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_mask = 4'b0001;
      F3_H, F3_HU: size_mask = 4'b0011;
      F3_W:        size_mask = 4'b1111;
      default:     size_mask = 4'b0000;
    endcase
  endfunction

  // Unsigned widths only make sense for loads.
  function automatic logic func3_legal(input logic wr, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: func3_legal = 1'b1;
      F3_BU, F3_HU:     func3_legal = ~wr;
      default:          func3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
// Ports:
//   func3   - captured width code
//   offset  - byte offset within the first word (addr[1:0])
//   wdata   - LSB-aligned store data
//   lo, hi  - bus read words of the first and second access
//   mask8   - byte mask across two words; [3:0] first word, [7:4] second
//   wdata64 - store data shifted onto byte lanes across two words
//   ldata   - load result, shifted down, truncated and extended
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]             func3,
  input  logic [1:0]             offset,
  input  logic [DataWidth-1:0]   wdata,
  input  logic [DataWidth-1:0]   lo,
  input  logic [DataWidth-1:0]   hi,
  output logic [7:0]             mask8,
  output logic [2*DataWidth-1:0] wdata64,
  output logic [DataWidth-1:0]   ldata
);

  logic [4:0]           shamt;
  logic [DataWidth-1:0] sh;

  assign shamt   = {offset, 3'b000};
  assign mask8   = {4'b0000, size_mask(func3)} << offset;
  assign wdata64 = {{DataWidth{1'b0}}, wdata} << shamt;
  // For unsplit accesses the wanted bytes all sit in lo, so stale hi
  // contents are discarded by the truncation below.
  assign sh      = DataWidth'({hi, lo} >> shamt);

  always_comb begin
    ldata = '0;
    case (func3)
      F3_B:    ldata = {{(DataWidth-8){sh[7]}}, sh[7:0]};
      F3_H:    ldata = {{(DataWidth-16){sh[15]}}, sh[15:0]};
      F3_W:    ldata = sh;
      F3_BU:   ldata = {{(DataWidth-8){1'b0}}, sh[7:0]};
      F3_HU:   ldata = {{(DataWidth-16){1'b0}}, sh[15:0]};
      default: ldata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline load/store request into one or two
// word-aligned bus accesses (split when the access crosses a word boundary)
// and returns an extended load result with a one-cycle rspValid pulse.
// Ports:
//   clk, rst                   - clock, async active-high reset
//   reqValid/reqWrite/func3/addr/wdata - pipeline request
//   stall                      - freeze pipeline while a request is in flight
//   rspValid/rdata/err         - completion pulse, load data, illegal func3
//   memReq/memWe/memAddr/memBe/memWdata - bus request, held until memAck
//   memAck/memRdata            - bus completion and read data
//
// state | meaning
// IDLE  | waiting for reqValid; request captured on entry to ACC0/DONE
// ACC0  | first (or only) word access on the bus
// ACC1  | second word access of a split request
// DONE  | one-cycle response: rspValid, rdata, err
module load_store_unit #(
  parameter int AddrWidth = load_store_unit_pkg::AddrWidth,
  parameter int DataWidth = load_store_unit_pkg::DataWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reqValid,
  input  logic                 reqWrite,
  input  logic [2:0]           func3,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] wdata,
  output logic                 stall,
  output logic                 rspValid,
  output logic [DataWidth-1:0] rdata,
  output logic                 err,
  output logic                 memReq,
  output logic                 memWe,
  output logic [AddrWidth-1:0] memAddr,
  output logic [3:0]           memBe,
  output logic [DataWidth-1:0] memWdata,
  input  logic                 memAck,
  input  logic [DataWidth-1:0] memRdata
);
  import load_store_unit_pkg::*;

  state_t                 state, state_nxt;
  logic                   q_write, q_err;
  logic [2:0]             q_func3;
  logic [AddrWidth-1:0]   q_addr;
  logic [DataWidth-1:0]   q_wdata, q_lo, q_hi;
  logic [7:0]             mask8;
  logic [2*DataWidth-1:0] wdata64;
  logic [DataWidth-1:0]   ldata;
  logic [AddrWidth-1:0]   word_addr;
  logic                   split;

  lsu_align u_align (
    .func3  (q_func3),
    .offset (q_addr[1:0]),
    .wdata  (q_wdata),
    .lo     (q_lo),
    .hi     (q_hi),
    .mask8  (mask8),
    .wdata64(wdata64),
    .ldata  (ldata)
  );

  assign word_addr = {q_addr[AddrWidth-1:2], 2'b00};
  assign split     = |mask8[7:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_write <= 1'b0;
      q_err   <= 1'b0;
      q_func3 <= '0;
      q_addr  <= '0;
      q_wdata <= '0;
      q_lo    <= '0;
      q_hi    <= '0;
    end else begin
      if (state == IDLE && reqValid) begin
        q_write <= reqWrite;
        q_err   <= ~func3_legal(reqWrite, func3);
        q_func3 <= func3;
        q_addr  <= addr;
        q_wdata <= wdata;
      end
      if (state == ACC0 && memAck) q_lo <= memRdata;
      if (state == ACC1 && memAck) q_hi <= memRdata;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    rspValid  = 1'b0;
    rdata     = '0;
    err       = 1'b0;
    memReq    = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memBe     = 4'b0000;
    memWdata  = '0;
    case (state)
      IDLE: begin
        if (reqValid) begin
          stall     = 1'b1;
          state_nxt = func3_legal(reqWrite, func3) ? ACC0 : DONE;
        end
      end
      ACC0: begin
        stall    = 1'b1;
        memReq   = 1'b1;
        memWe    = q_write;
        memAddr  = word_addr;
        memBe    = mask8[3:0];
        memWdata = wdata64[DataWidth-1:0];
        if (memAck) state_nxt = split ? ACC1 : DONE;
      end
      ACC1: begin
        stall    = 1'b1;
        memReq   = 1'b1;
        memWe    = q_write;
        memAddr  = word_addr + AddrWidth'(4);
        memBe    = mask8[7:4];
        memWdata = wdata64[2*DataWidth-1:DataWidth];
        if (memAck) state_nxt = DONE;
      end
      DONE: begin
        rspValid  = 1'b1;
        err       = q_err;
        rdata     = (q_write || q_err) ? '0 : ldata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqWrite = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall, rspValid, err, memReq, memWe;
  logic [31:0] rdata, memAddr, memWdata;
  logic [3:0]  memBe;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk     (clk),
    .rst     (rst),
    .reqValid(reqValid),
    .reqWrite(reqWrite),
    .func3   (func3),
    .addr    (addr),
    .wdata   (wdata),
    .stall   (stall),
    .rspValid(rspValid),
    .rdata   (rdata),
    .err     (err),
    .memReq  (memReq),
    .memWe   (memWe),
    .memAddr (memAddr),
    .memBe   (memBe),
    .memWdata(memWdata),
    .memAck  (memAck),
    .memRdata(memRdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in IDLE for one cycle; returns one cycle later.
  task automatic issue(input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    reqValid = 1'b1;
    reqWrite = wr;
    func3    = f3;
    addr     = a;
    wdata    = wd;
    #1;
    check("issue_stall", 32'(stall), 32'd1);
    check("issue_memreq", 32'(memReq), 32'd0);
    tick();
    reqValid = 1'b0;
  endtask

  // Checks a bus access held for `waits` cycles, then acks with rd.
  task automatic access(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                        input logic ewe, input logic [31:0] ewd, input int waits,
                        input logic [31:0] rd);
    logic [31:0] m;
    m = {{8{ebe[3]}}, {8{ebe[2]}}, {8{ebe[1]}}, {8{ebe[0]}}};
    for (int i = 0; i <= waits; i++) begin
      check({tag, "_req"},   32'(memReq), 32'd1);
      check({tag, "_stall"}, 32'(stall),  32'd1);
      check({tag, "_addr"},  memAddr,     ea);
      check({tag, "_be"},    32'(memBe),  32'(ebe));
      check({tag, "_we"},    32'(memWe),  32'(ewe));
      if (ewe) check({tag, "_wdata"}, memWdata & m, ewd & m);
      if (i == waits) begin
        memAck   = 1'b1;
        memRdata = rd;
      end
      tick();
    end
    memAck   = 1'b0;
    memRdata = 32'd0;
  endtask

  task automatic done(input string tag, input logic [31:0] erd, input logic eerr);
    check({tag, "_rsp"},   32'(rspValid), 32'd1);
    check({tag, "_err"},   32'(err),      32'(eerr));
    check({tag, "_rdata"}, rdata,         erd);
    check({tag, "_stall"}, 32'(stall),    32'd0);
    check({tag, "_noreq"}, 32'(memReq),   32'd0);
    tick();
    check({tag, "_rsp_end"}, 32'(rspValid), 32'd0);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_memreq",   32'(memReq),   32'd0);
    check("rst_memwe",    32'(memWe),    32'd0);
    check("rst_membe",    32'(memBe),    32'd0);
    check("rst_memaddr",  memAddr,       32'd0);
    check("rst_memwdata", memWdata,      32'd0);
    check("rst_rsp",      32'(rspValid), 32'd0);
    check("rst_rdata",    rdata,         32'd0);
    check("rst_err",      32'(err),      32'd0);
    check("rst_stall",    32'(stall),    32'd0);
    rst = 1'b0;
    tick();

    // sw 0x100, zero-wait ack -> rspValid two cycles after request
    issue(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF);
    access("sw", 32'h0000_0100, 4'b1111, 1'b1, 32'hDEAD_BEEF, 0, 32'd0);
    done("sw", 32'd0, 1'b0);

    // lh 0x103 split: 0x80 from top byte of first word, 0x7F from bottom of second
    issue(1'b0, 3'd1, 32'h0000_0103, 32'd0);
    access("lh_a0", 32'h0000_0100, 4'b1000, 1'b0, 32'd0, 1, 32'h8012_3456);
    access("lh_a1", 32'h0000_0104, 4'b0001, 1'b0, 32'd0, 0, 32'hABCD_EF7F);
    done("lh", 32'h0000_7F80, 1'b0);

    // illegal func3 = 3: no bus access, error response next cycle
    issue(1'b0, 3'd3, 32'h0000_0100, 32'd0);
    done("ill3", 32'd0, 1'b1);

    // store with unsigned width code is illegal
    issue(1'b1, 3'd4, 32'h0000_0100, 32'h1234_5678);
    done("sbu", 32'd0, 1'b1);

    // memAck with no request outstanding is ignored
    memAck = 1'b1;
    tick();
    check("stray_ack_req", 32'(memReq),   32'd0);
    check("stray_ack_rsp", 32'(rspValid), 32'd0);
    memAck = 1'b0;
    tick();
    check("stray_ack_rsp2", 32'(rspValid), 32'd0);

    // lw with two wait states; a new reqValid during the access is ignored
    issue(1'b0, 3'd2, 32'h0000_0300, 32'd0);
    reqValid = 1'b1;
    func3    = 3'd3;
    addr     = 32'h0000_0999;
    access("lw", 32'h0000_0300, 4'b1111, 1'b0, 32'd0, 2, 32'h1234_5678);
    done("lw", 32'h1234_5678, 1'b0);
    reqValid = 1'b0;

    // lh / lhu at offset 2, single access
    issue(1'b0, 3'd1, 32'h0000_0102, 32'd0);
    access("lh2", 32'h0000_0100, 4'b1100, 1'b0, 32'd0, 0, 32'hBEEF_0000);
    done("lh2", 32'hFFFF_BEEF, 1'b0);
    issue(1'b0, 3'd5, 32'h0000_0102, 32'd0);
    access("lhu2", 32'h0000_0100, 4'b1100, 1'b0, 32'd0, 0, 32'hBEEF_0000);
    done("lhu2", 32'h0000_BEEF, 1'b0);

    // sb at offset 1
    issue(1'b1, 3'd0, 32'h0000_0101, 32'h0000_00AB);
    access("sb", 32'h0000_0100, 4'b0010, 1'b1, 32'h0000_AB00, 0, 32'd0);
    done("sb", 32'd0, 1'b0);

    // reset while ACC1 is waiting abandons the access
    issue(1'b0, 3'd1, 32'h0000_0103, 32'd0);
    access("rsta0", 32'h0000_0100, 4'b1000, 1'b0, 32'd0, 0, 32'h8000_0000);
    check("rst_acc1_req", 32'(memReq), 32'd1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_req",   32'(memReq),   32'd0);
    check("rst_mid_addr",  memAddr,       32'd0);
    check("rst_mid_be",    32'(memBe),    32'd0);
    check("rst_mid_stall", 32'(stall),    32'd0);
    check("rst_mid_rsp",   32'(rspValid), 32'd0);
    tick();
    check("rst_hold_rsp", 32'(rspValid), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_after_rsp", 32'(rspValid), 32'd0);
    check("rst_after_req", 32'(memReq),   32'd0);

    // lb / lbu at offset 2 on 0x00850000
    issue(1'b0, 3'd0, 32'h0000_0202, 32'd0);
    access("lb", 32'h0000_0200, 4'b0100, 1'b0, 32'd0, 0, 32'h0085_0000);
    done("lb", 32'hFFFF_FF85, 1'b0);
    issue(1'b0, 3'd4, 32'h0000_0202, 32'd0);
    access("lbu", 32'h0000_0200, 4'b0100, 1'b0, 32'd0, 0, 32'h0085_0000);
    done("lbu", 32'h0000_0085, 1'b0);

    // sw at 0xFFFFFFFE splits and wraps the second address to 0
    issue(1'b1, 3'd2, 32'hFFFF_FFFE, 32'h1122_3344);
    access("swwr_a0", 32'hFFFF_FFFC, 4'b1100, 1'b1, 32'h3344_0000, 1, 32'd0);
    access("swwr_a1", 32'h0000_0000, 4'b0011, 1'b1, 32'h0000_1122, 0, 32'd0);
    done("swwr", 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one reset, rst; rst is asynchronous and active-high.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst  in  1  async active-high reset
- reqValid  in  1  pipeline load/store request
- reqWrite  in  1  1=store, 0=load
- func3  in  3  RV32 width code: 0 b, 1 h, 2 w, 4 bu, 5 hu
- addr  in  32  byte address
- wdata  in  32  store data, LSB-aligned
- stall  out  1  freeze pipeline
- rspValid  out  1  one-cycle completion pulse
- rdata  out  32  extended load result
- err  out  1  illegal func3, valid with rspValid
- memReq  out  1  bus request
- memWe  out  1  bus write
- memAddr  out  32  word-aligned bus address
- memBe  out  4  bus byte enables
- memWdata  out  32  lane-positioned bus write data
- memAck  in  1  bus completion
- memRdata  in  32  bus read data, valid with memAck

REQ-003 Parameters: AddrWidth, default 32, address width; DataWidth, default 32, data width.

Function
REQ-004 The block SHALL use an FSM with states IDLE, ACC0, ACC1 and DONE.
REQ-005 In IDLE with reqValid=1, the block SHALL capture the request and enter ACC0; for an illegal func3 (3, 6 or 7), or a store with func3 4 or 5, it SHALL enter DONE with err=1 and issue no bus access.
REQ-006 Size SHALL be 1, 2 or 4 bytes and offset o=addr[1:0]; mask8 = ((1<<size)-1)<<o; the access SHALL be split when mask8[7:4]!=0.
REQ-007 ACC0 SHALL drive memAddr={addr[31:2],00} and memBe=mask8[3:0]; ACC1 SHALL drive memAddr=ACC0 address+4, modulo 2^32 (0xFFFFFFFC wraps to 0x0), and memBe=mask8[7:4].
REQ-008 Store data SHALL be formed as a 64-bit value wdata<<(8*o); the low word SHALL go on memWdata in ACC0 and the high word in ACC1.
REQ-009 memReq SHALL be high throughout ACC0 and ACC1.
- memAddr, memWe, memBe and memWdata SHALL stay stable until memAck.
- memAck SHALL be ignored when memReq=0.
- A zero-wait ack in the first cycle of ACC0 or ACC1 SHALL be honoured.
REQ-010 On memAck in ACC0: for a split access, latch memRdata as the low word and go to ACC1; otherwise go to DONE.
REQ-011 On memAck in ACC1: latch memRdata as the high word and go to DONE.
REQ-012 For loads, rdata SHALL be ({hi,lo}>>(8*o)) truncated to size, sign-extended for func3 0/1 and zero-extended for func3 2/4/5; rdata SHALL be 0 for stores and on err.
REQ-013 DONE SHALL last exactly one cycle with rspValid=1, then return to IDLE; reqValid SHALL be ignored outside IDLE.
REQ-014 stall SHALL be high in ACC0 and ACC1, and combinationally high in IDLE when reqValid=1; it SHALL be low in DONE.
REQ-015 Latency SHALL be request -> rspValid = 2 + wait cycles for a single access, or 3 + waits for a split access; an illegal request SHALL respond in 1 cycle.

Reset
REQ-016 While rst=1, outputs SHALL be:
- state=IDLE
- memReq=0, memWe=0, memBe=0, memAddr=0, memWdata=0
- rspValid=0, rdata=0, err=0
REQ-017 rst asserted mid-access SHALL abandon the access immediately with no rspValid; the bus SHALL tolerate a dropped memReq.

Structure
REQ-018 A shared package SHALL hold the func3 encodings, the FSM state type, AddrWidth and DataWidth.
REQ-019 The combinational mask, shift and extend logic SHALL be a sub-module named lsu_align; the FSM and registers SHALL stay in load_store_unit.

Verification
REQ-020 sw addr=0x100, wdata=0xDEADBEEF, memAck in the first cycle -> one access at 0x100 with be=1111; rspValid at cycle 2.
REQ-021 lh addr=0x103, memRdata=0x80xxxxxx then 0xxxxxxx7F -> accesses at 0x100 be=1000, then 0x104 be=0001; rdata=0x00007F80.
REQ-022 lb addr=0x202 with word=0x00850000 -> rdata=0xFFFFFF85; lbu on the same word -> rdata=0x00000085.
REQ-023 sw addr=0xFFFFFFFE, wdata=0x11223344 -> 0xFFFFFFFC be=1100 data=0x3344xxxx, then 0x00000000 be=0011 data=0xxxxx1122.
REQ-024 func3=3 -> no memReq, rspValid and err both 1 the next cycle; rst during ACC1 wait -> memReq=0 immediately, state=IDLE, no rspValid.
